// File: rtl/oldland_fwd_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : oldland_fwd_unit_if
//  Purpose  : Bundles the decode, regfile, forwarding, scoreboard and result
//             signals of the oldland operand forwarding / hazard unit.
//             The pipeline side uses the master modport. The forwarding unit
//             uses the slave modport.
//  Signals  :
//    d_valid, d_rsel, d_ruse  decode-stage instruction and its read selects
//    e_advance, flush         decode->execute transfer, execute-stage kill
//    rf_data                  regfile read data for the execute stage
//    fwd_valid, fwd_rd_sel,
//    fwd_ready, fwd_data      in-flight results, index 0 = youngest
//    sb_set/_sel, sb_clr/_sel long-latency write issue / retire
//    op_data, e_rsel          forwarded operands, execute-stage selects
//    stall, stall_count       hazard indication and saturating stall count
//  Revision : 1.0  initial release
// ============================================================================
interface oldland_fwd_unit_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int NUM_READ_PORTS = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int CNT_WIDTH      = 32
);
    logic                                     d_valid;
    logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] d_rsel;
    logic [NUM_READ_PORTS-1:0]                d_ruse;
    logic                                     e_advance;
    logic                                     flush;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     rf_data;
    logic [NUM_FWD_STAGES-1:0]                fwd_valid;
    logic [NUM_FWD_STAGES*REG_ADDR_WIDTH-1:0] fwd_rd_sel;
    logic [NUM_FWD_STAGES-1:0]                fwd_ready;
    logic [NUM_FWD_STAGES*DATA_WIDTH-1:0]     fwd_data;
    logic                                     sb_set;
    logic [REG_ADDR_WIDTH-1:0]                sb_set_sel;
    logic                                     sb_clr;
    logic [REG_ADDR_WIDTH-1:0]                sb_clr_sel;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     op_data;
    logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] e_rsel;
    logic                                     stall;
    logic [CNT_WIDTH-1:0]                     stall_count;

    modport master (
        output d_valid, d_rsel, d_ruse, e_advance, flush, rf_data,
               fwd_valid, fwd_rd_sel, fwd_ready, fwd_data,
               sb_set, sb_set_sel, sb_clr, sb_clr_sel,
        input  op_data, e_rsel, stall, stall_count
    );

    modport slave (
        input  d_valid, d_rsel, d_ruse, e_advance, flush, rf_data,
               fwd_valid, fwd_rd_sel, fwd_ready, fwd_data,
               sb_set, sb_set_sel, sb_clr, sb_clr_sel,
        output op_data, e_rsel, stall, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/oldland_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : oldland_fwd_unit
//  Purpose  : Operand forwarding and hazard unit for the oldland pipeline.
//             It registers the decode read selects into the execute stage.
//             It takes each execute operand from the youngest matching
//             in-flight result, or from the regfile when nothing matches.
//             It raises stall when an operand is not yet available. That is
//             the case for a load in flight, or for a pending long-latency
//             write tracked in a per-register scoreboard. It also counts
//             stalled cycles, saturating at the top of the counter.
//  Ports    :
//    clk   clock
//    rst   synchronous active-high reset
//    bus   oldland_fwd_unit_if.slave, which carries:
//            decode selects and use bits
//            the e_advance and flush controls
//            regfile data
//            forwarding sources (valid/rd/ready/data per stage)
//            scoreboard set/clear
//            and, as outputs: op_data, e_rsel, stall, stall_count
//  Revision : 1.0  initial release
// ============================================================================
module oldland_fwd_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int NUM_READ_PORTS = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic              clk,
    input  logic              rst,
    oldland_fwd_unit_if.slave bus
);
    localparam int c_NUM_REGS = 1 << REG_ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Execute-stage state.
    logic                                     r_e_valid;
    logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] r_e_rsel;
    logic [NUM_READ_PORTS-1:0]                r_e_ruse;

    // A set bit means a long-latency write to that register is still pending.
    logic [c_NUM_REGS-1:0]                    r_scoreboard;
    logic [c_NUM_REGS-1:0]                    w_sb_next;

    logic [CNT_WIDTH-1:0]                     r_stall_count;

    logic [NUM_READ_PORTS-1:0]                w_hazard;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     w_op_data;
    logic                                     w_stall;

    // ------------------------------------------------------------------
    // Decode -> execute registers. A flush that coincides with an
    // advance kills the incoming instruction, so the stage is never
    // left holding a wrong-path instruction.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_valid <= 1'b0;
            r_e_rsel  <= '0;
            r_e_ruse  <= '0;
        end else if (bus.e_advance) begin
            r_e_valid <= bus.d_valid & ~bus.flush;
            r_e_rsel  <= bus.d_rsel;
            r_e_ruse  <= bus.d_ruse;
        end else if (bus.flush) begin
            r_e_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard update. The set is applied after the clear. A new issue
    // to a register therefore wins over a retire to the same register in
    // the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_sb_next = r_scoreboard;
        if (bus.sb_clr) begin
            w_sb_next[bus.sb_clr_sel] = 1'b0;
        end
        if (bus.sb_set) begin
            w_sb_next[bus.sb_set_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scoreboard <= '0;
        end else begin
            r_scoreboard <= w_sb_next;
        end
    end

    // ------------------------------------------------------------------
    // Per-port operand mux and hazard detection.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        logic [REG_ADDR_WIDTH-1:0] w_sel;
        logic                      w_match;
        logic                      w_ready;
        logic [DATA_WIDTH-1:0]     w_data;

        assign w_sel = r_e_rsel[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

        // The scan runs from oldest to youngest. A later (younger) hit
        // overwrites an earlier one, so the lowest stage index wins.
        always_comb begin
            w_match = 1'b0;
            w_ready = 1'b1;
            w_data  = bus.rf_data[p*DATA_WIDTH +: DATA_WIDTH];
            for (int s = NUM_FWD_STAGES - 1; s >= 0; s--) begin
                if (bus.fwd_valid[s] &&
                    (bus.fwd_rd_sel[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == w_sel)) begin
                    w_match = 1'b1;
                    w_ready = bus.fwd_ready[s];
                    w_data  = bus.fwd_data[s*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end

        // A matching in-flight result is newer than any pending
        // long-latency write. It therefore decides alone whether the
        // operand is available. The scoreboard is only consulted on a miss.
        assign w_hazard[p] = r_e_valid & r_e_ruse[p] &
                             (w_match ? ~w_ready : r_scoreboard[w_sel]);

        assign w_op_data[p*DATA_WIDTH +: DATA_WIDTH] = w_data;
    end

    assign w_stall = |w_hazard;

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter. Only reset clears it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != c_CNT_MAX)) begin
            r_stall_count <= r_stall_count + c_CNT_ONE;
        end
    end

    assign bus.op_data     = w_op_data;
    assign bus.e_rsel      = r_e_rsel;
    assign bus.stall       = w_stall;
    assign bus.stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_oldland_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oldland_fwd_unit
//  Purpose  : Directed self-checking bench for oldland_fwd_unit. A second
//             instance with a 4-bit counter shares the same stimulus and
//             exercises counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_oldland_fwd_unit;
    localparam int K_STALL = 0;
    localparam int K_OP0   = 1;
    localparam int K_OP1   = 2;
    localparam int K_CNT   = 3;
    localparam int K_SAT   = 4;
    localparam int K_ERSEL = 5;

    localparam logic [31:0] RF0 = 32'hA0A0_0000;
    localparam logic [31:0] RF1 = 32'hB1B1_0001;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    oldland_fwd_unit_if #(.CNT_WIDTH(32)) bus ();
    oldland_fwd_unit_if #(.CNT_WIDTH(4))  sat_bus ();

    oldland_fwd_unit #(.CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    oldland_fwd_unit #(.CNT_WIDTH(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sat_bus.slave)
    );

    assign sat_bus.d_valid    = bus.d_valid;
    assign sat_bus.d_rsel     = bus.d_rsel;
    assign sat_bus.d_ruse     = bus.d_ruse;
    assign sat_bus.e_advance  = bus.e_advance;
    assign sat_bus.flush      = bus.flush;
    assign sat_bus.rf_data    = bus.rf_data;
    assign sat_bus.fwd_valid  = bus.fwd_valid;
    assign sat_bus.fwd_rd_sel = bus.fwd_rd_sel;
    assign sat_bus.fwd_ready  = bus.fwd_ready;
    assign sat_bus.fwd_data   = bus.fwd_data;
    assign sat_bus.sb_set     = bus.sb_set;
    assign sat_bus.sb_set_sel = bus.sb_set_sel;
    assign sat_bus.sb_clr     = bus.sb_clr;
    assign sat_bus.sb_clr_sel = bus.sb_clr_sel;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_STALL: observe = {31'd0, bus.stall};
            K_OP0:   observe = bus.op_data[31:0];
            K_OP1:   observe = bus.op_data[63:32];
            K_CNT:   observe = bus.stall_count;
            K_SAT:   observe = {28'd0, sat_bus.stall_count};
            default: observe = {26'd0, bus.e_rsel};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic exp_sc(input string tag, input logic st, input logic [31:0] cnt);
        push({tag, ".stall"}, K_STALL, {31'd0, st});
        push({tag, ".count"}, K_CNT, cnt);
    endtask

    task automatic exp_all(input string tag, input logic st, input logic [31:0] o0,
                           input logic [31:0] o1, input logic [31:0] cnt);
        exp_sc(tag, st, cnt);
        push({tag, ".op0"}, K_OP0, o0);
        push({tag, ".op1"}, K_OP1, o1);
    endtask

    // Outputs are compared at the falling edge, away from the active edge.
    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.kind);
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic load(input logic [2:0] r0, input logic [2:0] r1,
                        input logic [1:0] use_bits, input logic fl);
        bus.d_valid   = 1'b1;
        bus.d_rsel    = {r1, r0};
        bus.d_ruse    = use_bits;
        bus.e_advance = 1'b1;
        bus.flush     = fl;
        tick();
        bus.d_valid   = 1'b0;
        bus.e_advance = 1'b0;
        bus.flush     = 1'b0;
    endtask

    initial begin
        bus.d_valid    = 1'b0;
        bus.d_rsel     = '0;
        bus.d_ruse     = '0;
        bus.e_advance  = 1'b0;
        bus.flush      = 1'b0;
        bus.rf_data    = {RF1, RF0};
        bus.fwd_valid  = '0;
        bus.fwd_rd_sel = '0;
        bus.fwd_ready  = '0;
        bus.fwd_data   = '0;
        bus.sb_set     = 1'b0;
        bus.sb_set_sel = '0;
        bus.sb_clr     = 1'b0;
        bus.sb_clr_sel = '0;

        // Reset
        tick();
        tick();
        exp_all("reset", 1'b0, RF0, RF1, 32'd0);
        push("reset.e_rsel", K_ERSEL, 32'd0);
        push("reset.sat", K_SAT, 32'd0);
        check();
        rst = 1'b0;

        // Back-to-back ALU forwarding, youngest wins
        load(3'd3, 3'd7, 2'b11, 1'b0);
        bus.fwd_valid  = 2'b11;
        bus.fwd_rd_sel = {3'd3, 3'd3};
        bus.fwd_ready  = 2'b11;
        bus.fwd_data   = {32'h0000_BEEF, 32'h0000_1234};
        exp_all("alu_youngest", 1'b0, 32'h0000_1234, RF1, 32'd0);
        push("alu.e_rsel", K_ERSEL, 32'h0000_003B);
        check();
        tick();
        bus.fwd_valid = 2'b10;
        exp_all("alu_stage1", 1'b0, 32'h0000_BEEF, RF1, 32'd0);
        check();
        tick();
        bus.fwd_valid  = 2'b01;
        bus.fwd_rd_sel = {3'd3, 3'd7};
        exp_all("alu_port1", 1'b0, RF0, 32'h0000_1234, 32'd0);
        check();
        tick();
        bus.fwd_valid = 2'b00;

        // Load-use stall until the load result is final
        load(3'd1, 3'd5, 2'b11, 1'b0);
        bus.fwd_valid  = 2'b01;
        bus.fwd_rd_sel = {3'd0, 3'd5};
        bus.fwd_ready  = 2'b00;
        bus.fwd_data   = '0;
        exp_sc("lu_c0", 1'b1, 32'd0);
        check();
        tick();
        exp_sc("lu_c1", 1'b1, 32'd1);
        check();
        tick();
        exp_sc("lu_c2", 1'b1, 32'd2);
        check();
        tick();
        bus.fwd_ready = 2'b01;
        bus.fwd_data  = {32'd0, 32'h0000_CAFE};
        exp_all("lu_ready", 1'b0, RF0, 32'h0000_CAFE, 32'd3);
        check();
        tick();
        exp_sc("lu_after", 1'b0, 32'd3);
        check();
        bus.fwd_valid = 2'b00;
        bus.fwd_ready = 2'b00;

        // Scoreboard set / clear
        bus.sb_set     = 1'b1;
        bus.sb_set_sel = 3'd2;
        load(3'd2, 3'd0, 2'b01, 1'b0);
        bus.sb_set = 1'b0;
        exp_sc("sb_set", 1'b1, 32'd3);
        check();
        tick();
        bus.sb_clr     = 1'b1;
        bus.sb_clr_sel = 3'd2;
        exp_sc("sb_clr_pending", 1'b1, 32'd4);
        check();
        tick();
        bus.sb_clr = 1'b0;
        exp_sc("sb_cleared", 1'b0, 32'd5);
        check();
        tick();
        bus.sb_set     = 1'b1;
        bus.sb_set_sel = 3'd2;
        bus.sb_clr     = 1'b1;
        bus.sb_clr_sel = 3'd2;
        exp_sc("sb_same_pre", 1'b0, 32'd5);
        check();
        tick();
        bus.sb_set = 1'b0;
        bus.sb_clr = 1'b0;
        exp_sc("sb_same_set_wins", 1'b1, 32'd5);
        check();
        tick();
        bus.sb_set     = 1'b1;
        bus.sb_set_sel = 3'd4;
        bus.sb_clr     = 1'b1;
        bus.sb_clr_sel = 3'd2;
        exp_sc("sb_diff_pre", 1'b1, 32'd6);
        check();
        tick();
        bus.sb_set = 1'b0;
        bus.sb_clr = 1'b0;
        exp_sc("sb_diff_r2_clr", 1'b0, 32'd7);
        check();

        // A ready forwarded match hides a set scoreboard bit
        load(3'd0, 3'd4, 2'b10, 1'b0);
        exp_sc("sb_r4_set", 1'b1, 32'd7);
        check();
        tick();
        bus.fwd_valid  = 2'b10;
        bus.fwd_rd_sel = {3'd4, 3'd0};
        bus.fwd_ready  = 2'b10;
        bus.fwd_data   = {32'h0000_4444, 32'd0};
        exp_all("fwd_hides_sb", 1'b0, RF0, 32'h0000_4444, 32'd8);
        check();
        tick();
        bus.fwd_valid = 2'b00;
        bus.fwd_ready = 2'b00;
        exp_sc("sb_visible_again", 1'b1, 32'd8);
        check();

        // Flush kills the stalled execute instruction
        tick();
        bus.flush = 1'b1;
        exp_sc("flush_pre", 1'b1, 32'd9);
        check();
        tick();
        bus.flush = 1'b0;
        exp_sc("flush_post", 1'b0, 32'd10);
        check();

        // Unused port reading a scoreboarded register never stalls
        load(3'd0, 3'd4, 2'b01, 1'b0);
        exp_sc("unused_port", 1'b0, 32'd10);
        push("unused.e_rsel", K_ERSEL, 32'h0000_0020);
        check();

        // Flush coinciding with advance kills the incoming instruction
        load(3'd0, 3'd4, 2'b10, 1'b1);
        exp_sc("flush_advance", 1'b0, 32'd10);
        check();

        // Reset in the middle of a stall
        load(3'd0, 3'd4, 2'b10, 1'b0);
        exp_sc("rst_pre_stall", 1'b1, 32'd10);
        check();
        tick();
        rst = 1'b1;
        exp_sc("rst_asserted", 1'b1, 32'd11);
        check();
        tick();
        rst = 1'b0;
        exp_sc("rst_mid_stall", 1'b0, 32'd0);
        push("rst_mid.sat", K_SAT, 32'd0);
        check();
        load(3'd0, 3'd4, 2'b10, 1'b0);
        exp_sc("rst_sb_empty", 1'b0, 32'd0);
        check();

        // Counter saturation on the 4-bit instance
        bus.sb_set     = 1'b1;
        bus.sb_set_sel = 3'd4;
        tick();
        bus.sb_set = 1'b0;
        exp_sc("sat_start", 1'b1, 32'd0);
        push("sat_start.sat", K_SAT, 32'd0);
        check();
        repeat (14) tick();
        exp_sc("sat_14", 1'b1, 32'd14);
        push("sat_14.sat", K_SAT, 32'd14);
        check();
        repeat (6) tick();
        exp_sc("sat_20", 1'b1, 32'd20);
        push("sat_20.sat", K_SAT, 32'd15);
        check();
        bus.sb_clr     = 1'b1;
        bus.sb_clr_sel = 3'd4;
        tick();
        bus.sb_clr = 1'b0;
        exp_sc("sat_release", 1'b0, 32'd21);
        push("sat_release.sat", K_SAT, 32'd15);
        check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
